// File: rtl/full_adder_pkg.sv
// Shared sizing constants for the full_adder block.
package full_adder_pkg;

    localparam int FA_WIDTH_DEFAULT = 1;
    localparam int FA_WIDTH_MIN     = 1;
    localparam int FA_WIDTH_MAX     = 64;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell; chained by full_adder to form the ripple carry path.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with one-cycle latency.
// Optional registered signed-overflow output enabled by FULL_ADDER_OVF_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < FA_WIDTH_MIN || WIDTH > FA_WIDTH_MAX) begin : g_width_check
        $error("full_adder: WIDTH=%0d outside legal range %0d..%0d",
               WIDTH, FA_WIDTH_MIN, FA_WIDTH_MAX);
    end

    // Stage p0: combinational ripple chain, c[0] is the carry-in
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_bit u_fa_bit (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    // Stage p1: output registers; data holds when no new input is accepted
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1  <= s;
                cout_p1 <= c[WIDTH];
            end
        end
    end

    assign sum       = sum_p1;
    assign cout      = cout_p1;
    assign out_valid = vld_p1;

`ifdef FULL_ADDER_OVF_EN
    logic ovf_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p1 <= 1'b0;
        end else if (in_valid) begin
            ovf_p1 <= c[WIDTH] ^ c[WIDTH-1];
        end
    end

    assign ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1, 8 and 16.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       s1, co1, vo1;
    logic       iv8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       co8, vo8;
    logic        iv16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        co16, vo16;
`ifdef FULL_ADDER_OVF_EN
    logic ov1, ov8, ov16;
`endif

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .sum(s1), .cout(co1), .out_valid(vo1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(ov1)
`endif
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .cout(co8), .out_valid(vo8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(ov8)
`endif
    );

    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16), .cin(cin16),
        .sum(s16), .cout(co16), .out_valid(vo16)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(ov16)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed overflow from the operand values: true result outside w-bit two's-complement range.
    function automatic logic ovf_ref(input longint ua, input longint ub, input longint uc, input int w);
        longint sa, sb, r, half;
        half = longint'(1) << (w - 1);
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        r  = sa + sb + uc;
        return (r > half - 1) || (r < -half);
    endfunction

    logic [16:0] exp16;
    logic [8:0]  hold8;
    logic        hold_ovf8;

    initial begin
        // Asynchronous reset assertion, well before the first clock edge
        #3 rst_n = 1'b0;
        #2;
        check("rst_w1_sum", s1, 0);
        check("rst_w1_cout", co1, 0);
        check("rst_w1_vld", vo1, 0);
        check("rst_w8_sum", s8, 0);
        check("rst_w8_vld", vo8, 0);
        check("rst_w16_sum", {co16, s16}, 0);
        check("rst_w16_vld", vo16, 0);
`ifdef FULL_ADDER_OVF_EN
        check("rst_w8_ovf", ov8, 0);
`endif

        // Input presented while in reset must be discarded
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk); #1;
        check("rst_discard_vld", vo1, 0);
        check("rst_discard_sum", {co1, s1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive WIDTH=1 truth table, one input every 20 time units
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            {a1, b1, cin1} = v;
            iv1 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("w1_vld_%0d", k), vo1, 1);
            check($sformatf("w1_sum_%0d", k), {co1, s1}, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("w1_ovf_%0d", k), ov1, ovf_ref(v[2], v[1], v[0], 1));
`endif
        end
        iv1 = 1'b0;

        // WIDTH=8 boundary cases plus a few random operands
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       begin a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; end
                1:       begin a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; end
                2:       begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
                default: begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
            endcase
            iv8 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("w8_vld_%0d", k), vo8, 1);
            check($sformatf("w8_sum_%0d", k), {co8, s8}, 9'(a8) + 9'(b8) + 9'(cin8));
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("w8_ovf_%0d", k), ov8, ovf_ref(a8, b8, cin8, 8));
`endif
        end

        // One accepted input then three idle cycles: outputs must hold
        a8 = 8'd1; b8 = 8'd1; cin8 = 1'b0; iv8 = 1'b1;
        hold8 = 9'd2;
        hold_ovf8 = ovf_ref(1, 1, 0, 8);
        @(posedge clk); #1;
        check("hold_first_vld", vo8, 1);
        check("hold_first_sum", {co8, s8}, hold8);
        iv8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("hold_vld_%0d", k), vo8, 0);
            check($sformatf("hold_sum_%0d", k), {co8, s8}, hold8);
`ifdef FULL_ADDER_OVF_EN
            check($sformatf("hold_ovf_%0d", k), ov8, hold_ovf8);
`endif
        end

        // Mid-cycle asynchronous reset while a result is being presented
        a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        check("midrst_pre_vld", vo8, 1);
        check("midrst_pre_sum", {co8, s8}, 9'h111);
        iv8 = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        check("midrst_vld", vo8, 0);
        check("midrst_sum", {co8, s8}, 0);
`ifdef FULL_ADDER_OVF_EN
        check("midrst_ovf", ov8, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=16 back-to-back random stream, 1000 transactions
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            exp16 = 17'(a16) + 17'(b16) + 17'(cin16);
            @(posedge clk); #1;
            check($sformatf("w16_vld_%0d", i), vo16, 1);
            check($sformatf("w16_sum_%0d", i), {co16, s16}, exp16);
            if (i < 999) begin
                a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            end else begin
                iv16 = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("w16_vld_drop", vo16, 0);
        check("w16_sum_hold", {co16, s16}, exp16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
